// File: rtl/program_loader.sv
// Byte-stream program loader: takes a big-endian length-prefixed image, packs byte pairs into
// instruction words and writes them from address 0 while holding the CPU. Optional trailing
// XOR checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned INST_W   = 16,
  parameter int unsigned BYTE_W   = 8,
  parameter int unsigned I_ADDR_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BYTE_W-1:0]   byte_data,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic                imem_write_enable,
  output logic [I_ADDR_W-1:0] imem_address,
  output logic [INST_W-1:0]   imem_write_data,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_error
);

  localparam int unsigned LenW     = 2 * BYTE_W;
  localparam int unsigned MaxWords = 2 ** I_ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StDone, StError
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , StCheck
`endif
  } state_e;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_e StTail = StCheck;
`else
  localparam state_e StTail = StDone;
`endif

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   len_hi_q, len_hi_d;
  logic [BYTE_W-1:0]   data_hi_q, data_hi_d;
  logic [LenW-1:0]     count_q, count_d;
  logic [I_ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   csum_q, csum_d;
`endif

  logic [LenW-1:0] len_word;
  logic            xfer;

  assign byte_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                      (state_q == StCheck) ||
`endif
                      (state_q == StDataHi) || (state_q == StDataLo);
  assign xfer     = byte_valid && byte_ready;
  assign len_word = {len_hi_q, byte_data};

  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    data_hi_d = data_hi_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    hold_d    = hold_q;
    done_d    = 1'b0;
    err_d     = err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    if (xfer && state_q != StCheck) csum_d = csum_q ^ byte_data;
`endif
    // Address advances only after the write strobe has presented it.
    if (we_q) addr_d = addr_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = 1'b0;
          hold_d  = 1'b1;
          addr_d  = '0;
          state_d = StLenHi;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_hi_d = byte_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          count_d = len_word;
          if (32'(len_word) > MaxWords) begin
            err_d   = 1'b1;
            state_d = StError;
          end else if (len_word == '0) begin
            state_d = StTail;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (xfer) begin
          data_hi_d = byte_data;
          state_d   = StDataLo;
        end
      end
      StDataLo: begin
        if (xfer) begin
          wdata_d = {data_hi_q, byte_data};
          we_d    = 1'b1;
          count_d = count_q - 1'b1;
          state_d = (count_q == LenW'(1)) ? StTail : StDataHi;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (xfer) begin
          if (byte_data == csum_q) begin
            state_d = StDone;
          end else begin
            err_d   = 1'b1;
            state_d = StError;
          end
        end
      end
`endif
      StDone: begin
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = StIdle;
      end
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      len_hi_q  <= '0;
      data_hi_q <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      data_hi_q <= data_hi_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign imem_write_enable = we_q;
  assign imem_address      = addr_q;
  assign imem_write_data   = wdata_q;
  assign cpu_hold          = hold_q;
  assign load_done         = done_q;
  assign load_error        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: byte images with random gaps, checked against a
// length/word/checksum model of the image format.
module tb_program_loader;

  localparam int unsigned InstW  = 16;
  localparam int unsigned ByteW  = 8;
  localparam int unsigned IAddrW = 12;
  localparam int          Cap    = 1 << IAddrW;

  typedef logic [7:0] bytes_t[$];

  logic              clk = 1'b0;
  logic              reset, start, byte_valid;
  logic [ByteW-1:0]  byte_data;
  logic              byte_ready, imem_write_enable, cpu_hold, load_done, load_error;
  logic [IAddrW-1:0] imem_address;
  logic [InstW-1:0]  imem_write_data;

  always #5 clk = ~clk;

  program_loader #(.INST_W(InstW), .BYTE_W(ByteW), .I_ADDR_W(IAddrW)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_write_enable(imem_write_enable),
    .imem_address(imem_address), .imem_write_data(imem_write_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write/done monitor.
  logic [IAddrW-1:0] got_addr[$];
  logic [InstW-1:0]  got_data[$];
  int                done_cnt;
  int                writes_at_done;

  always @(negedge clk) begin
    if (load_done) begin
      done_cnt++;
      writes_at_done = got_addr.size();
      check_eq("hold_falls_with_done", {31'd0, cpu_hold}, 32'd0);
    end
    if (imem_write_enable) begin
      got_addr.push_back(imem_address);
      got_data.push_back(imem_write_data);
      check_eq("hold_during_write", {31'd0, cpu_hold}, 32'd1);
    end
  end

  function automatic bytes_t seal(input bytes_t q);
    bytes_t r = q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  function automatic bytes_t make_image(input int n);
    bytes_t q;
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom_range(255, 0)));
    return seal(q);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit noise);
    bit ok = 0;
    int gap = $urandom_range(max_gap, 0);
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    if (noise) start = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (byte_ready) ok = 1;
      @(posedge clk);
    end
    #1;
    byte_valid = 1'b0;
    start      = 1'b0;
    check_eq("byte_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic begin_session(input string name);
    got_addr.delete();
    got_data.delete();
    done_cnt       = 0;
    writes_at_done = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check_eq({name, "_hold_on"}, {31'd0, cpu_hold}, 32'd1);
    check_eq({name, "_err_clr"}, {31'd0, load_error}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_session(input bytes_t img, input int max_gap, input bit noise,
                             input string name);
    int n, exp_words, nw;
    bit exp_err, timeout;
    begin_session(name);
    for (int i = 0; i < img.size(); i++) send_byte(img[i], max_gap, noise && (i + 1 < img.size()));

    // Reference: length word, overflow rule, then optional checksum over all prior bytes.
    n         = int'({img[0], img[1]});
    exp_err   = (n > Cap);
    exp_words = exp_err ? 0 : n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (!exp_err) begin
      logic [7:0] x = 8'h00;
      for (int i = 0; i < 2 + 2 * n; i++) x ^= img[i];
      exp_err = (img[2 + 2 * n] != x);
    end
`endif

    timeout = 1;
    for (int t = 0; t < 40 && timeout; t++) begin
      @(negedge clk);
      if (done_cnt > 0 || load_error) timeout = 0;
    end
    repeat (3) @(negedge clk);

    check_eq({name, "_end_timeout"}, {31'd0, timeout}, 32'd0);
    nw = got_addr.size();
    check_eq({name, "_nwrites"}, nw, exp_words);
    for (int k = 0; k < nw && k < exp_words; k++) begin
      check_eq({name, "_addr"}, {20'd0, got_addr[k]}, k % Cap);
      check_eq({name, "_data"}, {16'd0, got_data[k]}, {16'd0, img[2 + 2 * k], img[3 + 2 * k]});
    end
    check_eq({name, "_done_cnt"}, done_cnt, exp_err ? 0 : 1);
    if (!exp_err) check_eq({name, "_writes_before_done"}, writes_at_done, exp_words);
    check_eq({name, "_load_error"}, {31'd0, load_error}, {31'd0, exp_err});
    check_eq({name, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, exp_err});
    check_eq({name, "_ready_idle"}, {31'd0, byte_ready}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "_we"}, {31'd0, imem_write_enable}, 32'd0);
    check_eq({name, "_addr"}, {20'd0, imem_address}, 32'd0);
    check_eq({name, "_wdata"}, {16'd0, imem_write_data}, 32'd0);
    check_eq({name, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check_eq({name, "_done"}, {31'd0, load_done}, 32'd0);
    check_eq({name, "_err"}, {31'd0, load_error}, 32'd0);
    check_eq({name, "_ready"}, {31'd0, byte_ready}, 32'd0);
  endtask

  initial begin
    bytes_t img;
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_session(seal(img), 0, 0, "basic");
    check_eq("basic_word0", {16'd0, got_data[0]}, 32'h1234);
    run_session(seal(img), 5, 0, "gaps");

    img = '{8'h00, 8'h00};
    run_session(seal(img), 2, 0, "zero_len");

    img = '{8'h10, 8'h01};
    run_session(img, 3, 0, "overflow");
    repeat (4) @(negedge clk);
    check_eq("overflow_err_sticky", {31'd0, load_error}, 32'd1);
    check_eq("overflow_hold_sticky", {31'd0, cpu_hold}, 32'd1);
    @(posedge clk); #1;
    run_session(make_image(3), 4, 0, "after_overflow");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'hFF};
    run_session(img, 1, 0, "csum_bad");
`endif

    // Reset after the first data byte: the word must never be written.
    begin_session("rst_mid");
    send_byte(8'h00, 1, 0);
    send_byte(8'h01, 1, 0);
    send_byte(8'h12, 1, 0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    repeat (3) @(negedge clk);
    check_eq("rst_mid_nwrites", got_addr.size(), 0);
    @(posedge clk); #1;

    for (int s = 0; s < 6; s++) run_session(make_image($urandom_range(6, 0)), 5, s[0], "rand");

    run_session(make_image(Cap), 0, 0, "full");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
